// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, frame
// start byte and header field sizes.
package prog_loader_pkg;

    localparam int          ADDR_BYTES        = 4;
    localparam int          LEN_BYTES         = 4;
    localparam int          MEM_BYTES_DEFAULT = 16384;
    localparam logic [7:0]  MAGIC_DEFAULT     = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    // 33-bit end-of-image check so a huge length cannot wrap back into range.
    function automatic logic image_fits(input logic [31:0] base,
                                        input logic [31:0] len,
                                        input int unsigned mem_bytes);
        return ({1'b0, base} + {1'b0, len}) <= 33'(mem_bytes);
    endfunction

endpackage

// File: rtl/le_field_shift.sv
// Little-endian multi-byte field assembler. field_value already includes the
// byte being loaded this cycle, so the caller can use it when full is high.
module le_field_shift
    import prog_loader_pkg::*;
#(
    parameter int N_BYTES = ADDR_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   load,
    input  logic [7:0]             din,
    output logic [8*N_BYTES-1:0]   field_value,
    output logic                   full
);

    localparam int W  = 8 * N_BYTES;
    localparam int CW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  field_q, field_d;

    always_comb begin
        field_value = {din, field_q[W-1:8]};
        full        = load && (cnt_q == CW'(N_BYTES - 1));
        cnt_d       = cnt_q;
        field_d     = field_q;
        if (clr) begin
            cnt_d   = '0;
            field_d = '0;
        end else if (load) begin
            field_d = field_value;
            // Wrap after the last byte so the same instance serves the next field.
            cnt_d   = full ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            field_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            field_q <= field_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader into instruction memory; holds the CPU in reset
// until a good image lands. Checksum checking is enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter logic [7:0] MAGIC     = MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [2:0]  dbg_state
);

    // Handshake: a byte transfers when in_valid && in_ready; in_ready is always 1.

    state_e      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] len_q, len_d;
    logic [31:0] off_q, off_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif

    logic        fs_clr, fs_load, fs_full;
    logic [31:0] fs_value;
    logic        is_magic;
    logic        csum_ok;

    le_field_shift #(.N_BYTES(ADDR_BYTES)) u_field (
        .clk         (clk),
        .rst         (rst),
        .clr         (fs_clr),
        .load        (fs_load),
        .din         (in_data),
        .field_value (fs_value),
        .full        (fs_full)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        off_d       = off_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;
        fs_clr      = 1'b0;
        fs_load     = 1'b0;
        is_magic    = in_valid && (in_data == MAGIC);
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d       = xor_q;
        csum_ok     = (in_data == xor_q);
`else
        csum_ok     = 1'b1;
`endif

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (is_magic) begin
                    state_d    = ST_ADDR;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    off_d      = '0;
                    fs_clr     = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d      = '0;
`endif
                end
            end
            ST_ADDR: begin
                if (in_valid) begin
                    fs_load = 1'b1;
                    if (fs_full) begin
                        base_d  = fs_value;
                        state_d = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                if (in_valid) begin
                    fs_load = 1'b1;
                    if (fs_full) begin
                        len_d = fs_value;
                        off_d = '0;
                        if (!image_fits(base_q, fs_value, MEM_BYTES)) begin
                            state_d    = ST_ERR;
                            error_d    = 1'b1;
                            cpu_hold_d = 1'b1;
                        end else if (fs_value == '0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (in_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q + off_q;
                    mem_wdata_d = in_data;
                    off_d       = off_q + 32'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d       = xor_q ^ in_data;
`endif
                    if (off_q == len_q - 32'd1) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (in_valid) begin
                    if (csum_ok) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = ST_ERR;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            off_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            off_q       <= off_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    // A write registered last cycle must not land once reset is asserted.
    assign mem_we    = mem_we_q & ~rst;
    assign in_ready  = 1'b1;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule
